// File: rtl/adc128s_pkg.sv
// Shared definitions for the ADC128S SPI A2D converter model.
package adc128s_pkg;

  localparam logic [2:0] LC_LFT_ADDR  = 3'd0;
  localparam logic [2:0] LC_RGHT_ADDR = 3'd4;
  localparam logic [2:0] STEER_ADDR   = 3'd5;
  localparam logic [2:0] BATT_ADDR    = 3'd6;

  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  typedef logic [11:0] sample_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI line, plus a history flop
// that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic PRESET = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;
  logic [2:0] r_vld;

  // r_vld holds edges off until every stage holds a real sample, so a line
  // already low when reset drops does not look like a fresh falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {3{PRESET}};
      r_vld  <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
      r_vld  <= {r_vld[1:0], 1'b1};
    end
  end

  assign o_rise = r_vld[2] &  r_sync[1] & ~r_sync[2];
  assign o_fall = r_vld[2] & ~r_sync[1] &  r_sync[2];

endmodule

// File: rtl/adc128s_fc.sv
// Cycle-based ADC128S model: channel chosen in one 16-bit SPI frame is
// returned as a 12-bit sample in the following frame.
module adc128s_fc
  import adc128s_pkg::*;
#(
  parameter logic [2:0] LC_LFT_CH  = LC_LFT_ADDR,
  parameter logic [2:0] LC_RGHT_CH = LC_RGHT_ADDR,
  parameter logic [2:0] STEER_CH   = STEER_ADDR,
  parameter logic [2:0] BATT_CH    = BATT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_tx_shft;
  logic [15:0] r_rx_shft;
  logic [4:0]  r_bit_cnt;
  logic [2:0]  r_chnl_reg;
  logic [1:0]  r_mosi_sync;
  sample_t     w_sel;
  logic        w_ss_rise;
  logic        w_ss_fall;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_mosi;

  spi_sync_edge #(.PRESET(1'b1)) u_ss_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (SS_n),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  spi_sync_edge #(.PRESET(1'b1)) u_sclk_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (SCLK),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_mosi_sync <= 2'b00;
    else     r_mosi_sync <= {r_mosi_sync[0], MOSI};
  end

  assign w_mosi = r_mosi_sync[1];

  always_comb begin
    w_sel = 12'h000;
    if      (r_chnl_reg == LC_LFT_CH)  w_sel = ld_cell_lft;
    else if (r_chnl_reg == LC_RGHT_CH) w_sel = ld_cell_rght;
    else if (r_chnl_reg == STEER_CH)   w_sel = steerPot;
    else if (r_chnl_reg == BATT_CH)    w_sel = batt;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_next_state = XFER;
      XFER:    if (w_ss_rise) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // SS_n rise is checked before SCLK edges so a coincident clock edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_shft  <= 16'h0000;
      r_rx_shft  <= 16'h0000;
      r_bit_cnt  <= 5'd0;
      r_chnl_reg <= 3'd0;
    end else if (r_state == IDLE) begin
      if (w_ss_fall) begin
        r_tx_shft <= {4'b0000, w_sel};
        r_bit_cnt <= 5'd0;
      end
    end else if (w_ss_rise) begin
      if (r_bit_cnt == 5'(FRAME_BITS)) r_chnl_reg <= r_rx_shft[13:11];
    end else if (w_sclk_rise) begin
      if (r_bit_cnt != 5'(FRAME_BITS)) begin
        r_rx_shft <= (r_rx_shft << 1) | {15'd0, w_mosi};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end else if (w_sclk_fall && (r_bit_cnt != 5'd0)) begin
      r_tx_shft <= r_tx_shft << 1;
    end
  end

  assign MISO = (r_state == XFER) ? r_tx_shft[15] : 1'b0;

endmodule

// File: tb/tb_adc128s_fc.sv
// Directed bench for adc128s_fc: a mode-3 SPI master drives frames and checks
// the 16-bit words returned against hand-computed sample values.
module tb_adc128s_fc;

  logic        clk;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] ld_cell_lft;
  logic [11:0] ld_cell_rght;
  logic [11:0] steerPot;
  logic [11:0] batt;

  int nChecks;
  int nFails;

  adc128s_fc dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each SCLK level is held 5 clk; MISO is captured just before the rising edge.
  task automatic spiFrame(input logic [15:0] cmd, input int nbits, input bit collide,
                          output logic [15:0] rd);
    rd = 16'h0000;
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b1;
      repeat (5) @(negedge clk);
      if (i < 16) rd[15-i] = MISO;
      SCLK = 1'b1;
      if (collide && (i == nbits - 1)) SS_n = 1'b1;
      repeat (5) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    nChecks++;
    if (MISO !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_miso: got %b expected 0", MISO);
    end
    for (int k = 0; k < 4; k++) begin
      SCLK = ~SCLK;
      repeat (5) @(negedge clk);
      nChecks++;
      if (MISO !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL idle_sclk_%0d: got %b expected 0", k, MISO);
      end
    end
    SCLK = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ch0();
    logic [15:0] rd;
    for (int k = 0; k < 2; k++) begin
      spiFrame(16'h0000, 16, 1'b0, rd);
      nChecks++;
      if (rd !== 16'h0190) begin
        nFails++;
        $display("[TB] FAIL ch0_frame%0d: got %h expected 0190", k, rd);
      end
    end
  endtask

  task automatic test_channels();
    logic [15:0] rd;
    logic [15:0] cmds [4] = '{16'h2000, 16'h2800, 16'h3000, 16'h0000};
    logic [15:0] exps [4] = '{16'h0190, 16'h012C, 16'h00C8, 16'h08FF};
    for (int k = 0; k < 4; k++) begin
      spiFrame(cmds[k], 16, 1'b0, rd);
      nChecks++;
      if (rd !== exps[k]) begin
        nFails++;
        $display("[TB] FAIL channels_%0d: got %h expected %h", k, rd, exps[k]);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] rd;
    spiFrame(16'h1000, 16, 1'b0, rd);
    nChecks++;
    if (rd !== 16'h0190) begin
      nFails++;
      $display("[TB] FAIL unmapped_cmd: got %h expected 0190", rd);
    end
    spiFrame(16'h0000, 16, 1'b0, rd);
    nChecks++;
    if (rd !== 16'h0000) begin
      nFails++;
      $display("[TB] FAIL unmapped_read: got %h expected 0000", rd);
    end
  endtask

  task automatic test_abort();
    logic [15:0] rd;
    spiFrame(16'h3000, 16, 1'b0, rd);
    nChecks++;
    if (rd !== 16'h0190) begin
      nFails++;
      $display("[TB] FAIL abort_setup: got %h expected 0190", rd);
    end
    spiFrame(16'h2000, 8, 1'b0, rd);
    nChecks++;
    if (rd[15:8] !== 8'h08) begin
      nFails++;
      $display("[TB] FAIL abort_partial: got %h expected 08", rd[15:8]);
    end
    spiFrame(16'h0000, 16, 1'b0, rd);
    nChecks++;
    if (rd !== 16'h08FF) begin
      nFails++;
      $display("[TB] FAIL abort_keeps_ch: got %h expected 08ff", rd);
    end
  endtask

  task automatic test_collide();
    logic [15:0] rd;
    spiFrame(16'h2800, 16, 1'b1, rd);
    nChecks++;
    if (rd !== 16'h0190) begin
      nFails++;
      $display("[TB] FAIL collide_frame: got %h expected 0190", rd);
    end
    spiFrame(16'h0000, 16, 1'b0, rd);
    nChecks++;
    if (rd !== 16'h0190) begin
      nFails++;
      $display("[TB] FAIL collide_keeps_ch: got %h expected 0190", rd);
    end
  endtask

  task automatic test_overlength();
    logic [15:0] rd;
    spiFrame(16'h2800, 20, 1'b0, rd);
    nChecks++;
    if (rd !== 16'h0190) begin
      nFails++;
      $display("[TB] FAIL overlength_frame: got %h expected 0190", rd);
    end
    spiFrame(16'h0000, 16, 1'b0, rd);
    nChecks++;
    if (rd !== 16'h00C8) begin
      nFails++;
      $display("[TB] FAIL overlength_ch: got %h expected 00c8", rd);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rd;
    spiFrame(16'h2800, 16, 1'b0, rd);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0;
      MOSI = 1'b0;
      repeat (5) @(negedge clk);
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
    end
    SCLK = 1'b0;
    repeat (5) @(negedge clk);
    nChecks++;
    if (MISO !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL midframe_bit8: got %b expected 1", MISO);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nChecks++;
    if (MISO !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midframe_rst_miso: got %b expected 0", MISO);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      SCLK = ~SCLK;
      repeat (5) @(negedge clk);
      nChecks++;
      if (MISO !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL after_rst_sclk_%0d: got %b expected 0", k, MISO);
      end
    end
    SCLK = 1'b1;
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      spiFrame(16'h0000, 16, 1'b0, rd);
      nChecks++;
      if (rd !== 16'h0190) begin
        nFails++;
        $display("[TB] FAIL after_rst_frame%0d: got %h expected 0190", k, rd);
      end
    end
  endtask

  initial begin
    nChecks = 0;
    nFails = 0;
    ld_cell_lft  = 12'd400;
    ld_cell_rght = 12'd300;
    steerPot     = 12'd200;
    batt         = 12'h8FF;
    test_reset();
    test_ch0();
    test_channels();
    test_unmapped();
    test_abort();
    test_collide();
    test_overlength();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
